// File: rtl/wb_stage_seq.sv
// Write-back stage: holds one retired instruction, waits WB_DELAY cycles, then
// issues a single register-file write. Also exposes a forwarding view and a retire counter.
module wb_stage_seq #(
   parameter int DATA_W   = 32,
   parameter int WB_DELAY = 3,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       ir_i,
   input  logic [DATA_W-1:0] lmd_i,
   input  logic [DATA_W-1:0] aluo_i,
   input  logic [DATA_W-1:0] link_i,
   input  logic              cond_i,
   input  logic              flush,
   output logic              wb_we,
   output logic [4:0]        wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              cond_o,
   output logic              fwd_valid,
   output logic [4:0]        fwd_addr,
   output logic [DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]  retire_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      WB   = 2'd2
   } state_t;

   localparam logic [1:0] SEL_ALU  = 2'd0;
   localparam logic [1:0] SEL_LMD  = 2'd1;
   localparam logic [1:0] SEL_LINK = 2'd2;
   localparam logic [3:0] LAST_PH  = (WB_DELAY == 0) ? 4'd0 : 4'(WB_DELAY - 1);
   localparam state_t     CAP_ST   = (WB_DELAY == 0) ? WB : WAIT;

   // Returns {writes, data_select[1:0], dest[4:0]} for an instruction word.
   function automatic logic [7:0] wb_decode(input logic [31:0] ir);
      logic [7:0] d;
      d = 8'd0;
      case (ir[31:26])
         6'h00: begin
            if (ir[5:0] == 6'h08) begin
               d = 8'd0;
            end else if (ir[5:0] == 6'h09) begin
               d = {1'b1, SEL_LINK, ir[15:11]};
            end else begin
               d = {1'b1, SEL_ALU, ir[15:11]};
            end
         end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: d = {1'b1, SEL_LMD, ir[20:16]};
         6'h08, 6'h09, 6'h0A, 6'h0B,
         6'h0C, 6'h0D, 6'h0E, 6'h0F:        d = {1'b1, SEL_ALU, ir[20:16]};
         6'h03:                             d = {1'b1, SEL_LINK, 5'd31};
         default:                           d = 8'd0;
      endcase
      return d;
   endfunction

   state_t              state_r;
   logic [3:0]          cnt_r;
   logic [31:0]         ir_r;
   logic [DATA_W-1:0]   lmd_r;
   logic [DATA_W-1:0]   alu_r;
   logic [DATA_W-1:0]   link_r;
   logic                cond_r;
   logic [CNT_W-1:0]    retire_r;

   logic [7:0]          dec_s;
   logic                writes_s;
   logic [4:0]          addr_s;
   logic [DATA_W-1:0]   data_s;
   logic                accept_s;

   assign dec_s    = wb_decode(ir_r);
   assign addr_s   = dec_s[4:0];
   // Writes to r0 are architecturally discarded, so they never strobe or forward.
   assign writes_s = dec_s[7] & (addr_s != 5'd0);

   // Select write data from the held operands.
   always_comb begin
      data_s = alu_r;
      case (dec_s[6:5])
         SEL_LMD:  data_s = lmd_r;
         SEL_LINK: data_s = link_r;
         default:  data_s = alu_r;
      endcase
   end

   assign in_ready   = ~flush & ((state_r == IDLE) | (state_r == WB));
   assign accept_s   = in_valid & in_ready;
   assign wb_we      = (state_r == WB) & writes_s;
   assign fwd_valid  = ((state_r == WAIT) | (state_r == WB)) & writes_s;
   assign wb_addr    = addr_s;
   assign fwd_addr   = addr_s;
   assign wb_data    = data_s;
   assign fwd_data   = data_s;
   assign cond_o     = cond_r;
   assign retire_cnt = retire_r;

   // Instruction payload capture; accept_s is already blocked during flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ir_r   <= 32'd0;
         lmd_r  <= '0;
         alu_r  <= '0;
         link_r <= '0;
      end else if (accept_s) begin
         ir_r   <= ir_i;
         lmd_r  <= lmd_i;
         alu_r  <= aluo_i;
         link_r <= link_i;
      end else begin
         ir_r   <= ir_r;
         lmd_r  <= lmd_r;
         alu_r  <= alu_r;
         link_r <= link_r;
      end
   end

   // Sequencing FSM, phase counter, held condition and retire counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= IDLE;
         cnt_r    <= 4'd0;
         cond_r   <= 1'b0;
         retire_r <= '0;
      end else if (flush) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
         cond_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               cnt_r <= 4'd0;
               if (accept_s) begin
                  state_r <= CAP_ST;
                  cond_r  <= cond_i;
               end else begin
                  cond_r  <= 1'b0;
               end
            end
            WAIT: begin
               cnt_r <= cnt_r + 4'd1;
               if (cnt_r == LAST_PH) begin
                  state_r <= WB;
               end else begin
                  state_r <= WAIT;
               end
            end
            WB: begin
               retire_r <= retire_r + CNT_W'(1);
               cnt_r    <= 4'd0;
               if (accept_s) begin
                  state_r <= CAP_ST;
                  cond_r  <= cond_i;
               end else begin
                  state_r <= IDLE;
                  cond_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= 4'd0;
               cond_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_stage_seq.sv
// Randomized bench for wb_stage_seq: three instances (delays 3/0/2, counter widths 4/16/8)
// share the same stimulus and are each checked against a per-instruction reference model.
module tb_wb_stage_seq;

   localparam int NI        = 3;
   localparam int DLY [NI]  = '{3, 0, 2};
   localparam int CW  [NI]  = '{4, 16, 8};
   localparam int NCYC      = 3000;

   logic        clk = 1'b0;
   logic        rst, in_valid, flush, cond_i;
   logic [31:0] ir_i, lmd_i, aluo_i, link_i;

   logic [NI-1:0] rdy_w, we_w, cond_w, fv_w;
   logic [4:0]    wa_w [NI];
   logic [4:0]    fa_w [NI];
   logic [31:0]   wd_w [NI];
   logic [31:0]   fd_w [NI];
   logic [3:0]    rc0;
   logic [15:0]   rc1;
   logic [7:0]    rc2;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: one held instruction per instance, tracked by its age since capture.
   bit          m_busy [NI];
   int          m_age  [NI];
   bit          m_wr   [NI];
   logic [4:0]  m_addr [NI];
   logic [31:0] m_data [NI];
   bit          m_cond [NI];
   int unsigned m_cnt  [NI];
   bit          e_rdy  [NI];

   always #5 clk = ~clk;

   wb_stage_seq #(.DATA_W(32), .WB_DELAY(3), .CNT_W(4)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[0]), .ir_i(ir_i),
      .lmd_i(lmd_i), .aluo_i(aluo_i), .link_i(link_i), .cond_i(cond_i), .flush(flush),
      .wb_we(we_w[0]), .wb_addr(wa_w[0]), .wb_data(wd_w[0]), .cond_o(cond_w[0]),
      .fwd_valid(fv_w[0]), .fwd_addr(fa_w[0]), .fwd_data(fd_w[0]), .retire_cnt(rc0));

   wb_stage_seq #(.DATA_W(32), .WB_DELAY(0), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[1]), .ir_i(ir_i),
      .lmd_i(lmd_i), .aluo_i(aluo_i), .link_i(link_i), .cond_i(cond_i), .flush(flush),
      .wb_we(we_w[1]), .wb_addr(wa_w[1]), .wb_data(wd_w[1]), .cond_o(cond_w[1]),
      .fwd_valid(fv_w[1]), .fwd_addr(fa_w[1]), .fwd_data(fd_w[1]), .retire_cnt(rc1));

   wb_stage_seq #(.DATA_W(32), .WB_DELAY(2), .CNT_W(8)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[2]), .ir_i(ir_i),
      .lmd_i(lmd_i), .aluo_i(aluo_i), .link_i(link_i), .cond_i(cond_i), .flush(flush),
      .wb_we(we_w[2]), .wb_addr(wa_w[2]), .wb_data(wd_w[2]), .cond_o(cond_w[2]),
      .fwd_valid(fv_w[2]), .fwd_addr(fa_w[2]), .fwd_data(fd_w[2]), .retire_cnt(rc2));

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] get_rc(input int k);
      if (k == 0) return {12'd0, rc0};
      else if (k == 1) return rc1;
      else return {8'd0, rc2};
   endfunction

   // What the instruction writes, from the ISA rules.
   function automatic void ref_write(input logic [31:0] ir, input logic [31:0] lmd,
                                     input logic [31:0] alu, input logic [31:0] link,
                                     output bit wr, output logic [4:0] a, output logic [31:0] d);
      logic [5:0] op;
      logic [5:0] fn;
      op = ir[31:26];
      fn = ir[5:0];
      wr = 1'b0;
      a  = 5'd0;
      d  = alu;
      if (op == 6'h00) begin
         if (fn != 6'h08) begin
            wr = 1'b1;
            a  = ir[15:11];
            d  = (fn == 6'h09) ? link : alu;
         end
      end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
         wr = 1'b1; a = ir[20:16]; d = lmd;
      end else if (op >= 6'h08 && op <= 6'h0F) begin
         wr = 1'b1; a = ir[20:16]; d = alu;
      end else if (op == 6'h03) begin
         wr = 1'b1; a = 5'd31; d = link;
      end
      if (a == 5'd0) wr = 1'b0;
   endfunction

   function automatic logic [31:0] gen_ir();
      logic [5:0] loads  [5];
      logic [5:0] functs [5];
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rs, rt, rd;
      loads  = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
      functs = '{6'h08, 6'h09, 6'h20, 6'h21, 6'h2A};
      rs = 5'($urandom_range(0, 31));
      rt = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      fn = functs[$urandom_range(0, 4)];
      case ($urandom_range(0, 9))
         0, 1:    op = 6'h00;
         2:       op = loads[$urandom_range(0, 4)];
         3:       op = 6'h08 + 6'($urandom_range(0, 7));
         4:       op = 6'h03;
         5:       op = 6'h2B;
         6:       op = 6'h04;
         7:       op = 6'h02;
         default: op = 6'($urandom_range(0, 63));
      endcase
      return {op, rs, rt, rd, 5'd0, fn};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m_busy[k] = 1'b0; m_age[k] = 0; m_wr[k] = 1'b0;
         m_addr[k] = 5'd0; m_data[k] = 32'd0; m_cond[k] = 1'b0; m_cnt[k] = 0;
      end
   endtask

   task automatic check_outputs(input bit in_rst);
      for (int k = 0; k < NI; k++) begin
         bit last, e_we, e_fv;
         int unsigned mask;
         last     = m_busy[k] && (m_age[k] == DLY[k]);
         e_rdy[k] = !flush && (!m_busy[k] || last);
         e_we     = last && m_wr[k];
         e_fv     = m_busy[k] && m_wr[k];
         mask     = (32'd1 << CW[k]) - 32'd1;
         check_val($sformatf("u%0d in_ready", k), 64'(rdy_w[k]), 64'(e_rdy[k]));
         check_val($sformatf("u%0d wb_we", k), 64'(we_w[k]), 64'(e_we));
         check_val($sformatf("u%0d fwd_valid", k), 64'(fv_w[k]), 64'(e_fv));
         check_val($sformatf("u%0d cond_o", k), 64'(cond_w[k]), 64'(m_busy[k] ? m_cond[k] : 1'b0));
         check_val($sformatf("u%0d retire_cnt", k), 64'(get_rc(k)), 64'(m_cnt[k] & mask));
         if (e_we || in_rst) begin
            check_val($sformatf("u%0d wb_addr", k), 64'(wa_w[k]), 64'(m_addr[k]));
            check_val($sformatf("u%0d wb_data", k), 64'(wd_w[k]), 64'(m_data[k]));
         end
         if (e_fv || in_rst) begin
            check_val($sformatf("u%0d fwd_addr", k), 64'(fa_w[k]), 64'(m_addr[k]));
            check_val($sformatf("u%0d fwd_data", k), 64'(fd_w[k]), 64'(m_data[k]));
         end
      end
   endtask

   // Advance the model to the state after the coming rising edge.
   task automatic model_step();
      for (int k = 0; k < NI; k++) begin
         bit last;
         last = m_busy[k] && (m_age[k] == DLY[k]);
         if (flush) begin
            m_busy[k] = 1'b0;
         end else begin
            if (last) m_cnt[k]++;
            if (in_valid && e_rdy[k]) begin
               ref_write(ir_i, lmd_i, aluo_i, link_i, m_wr[k], m_addr[k], m_data[k]);
               m_busy[k] = 1'b1;
               m_age[k]  = 0;
               m_cond[k] = cond_i;
            end else if (last) begin
               m_busy[k] = 1'b0;
            end else if (m_busy[k]) begin
               m_age[k]++;
            end
         end
      end
   endtask

   initial begin
      logic [31:0] dq [$];
      bit          rst_done;
      rst_done = 1'b0;
      dq.push_back({6'h23, 5'd0, 5'd8, 16'h0000});              // lw r8
      dq.push_back({6'h09, 5'd1, 5'd5, 16'h0010});              // addiu r5
      dq.push_back({6'h00, 5'd1, 5'd2, 5'd9, 5'd0, 6'h20});     // add r9
      dq.push_back({6'h2B, 5'd1, 5'd3, 16'h0004});              // sw
      dq.push_back({6'h04, 5'd1, 5'd2, 16'h0008});              // beq
      dq.push_back({6'h03, 26'h0100004});                       // jal
      dq.push_back({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h21});     // addu r0

      rst = 1'b0; in_valid = 1'b0; flush = 1'b0; cond_i = 1'b0;
      ir_i = 32'd0; lmd_i = 32'd0; aluo_i = 32'd0; link_i = 32'd0;
      model_reset();
      #1;
      check_outputs(1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         rst = 1'b1;
         if (dq.size() > 0) begin
            in_valid = 1'b1;
            flush    = 1'b0;
            ir_i     = dq[0];
            lmd_i    = 32'hDEADBEEF;
            aluo_i   = $urandom;
            link_i   = 32'h00400010;
            cond_i   = 1'($urandom_range(0, 1));
         end else begin
            in_valid = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 13) == 0);
            ir_i     = gen_ir();
            lmd_i    = $urandom;
            aluo_i   = $urandom;
            link_i   = $urandom;
            cond_i   = 1'($urandom_range(0, 1));
         end
         #1;
         check_outputs(1'b0);
         if (dq.size() > 0 && in_valid && e_rdy[0]) void'(dq.pop_front());
         model_step();
         // Asynchronous reset landing while the slow instance is mid-wait.
         if (!rst_done && cyc > 400 && m_busy[0] && m_age[0] == 1) begin
            rst_done = 1'b1;
            #1;
            rst = 1'b0;
            flush = 1'b0;
            model_reset();
            #1;
            check_outputs(1'b1);
         end
      end

      check_val("reset_exercised", 64'(rst_done), 64'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
